// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, instruction classes, FSM states.
package decode_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_ALU_LO = 8'h01;
    localparam logic [7:0] OP_ALU_HI = 8'h1F;
    localparam logic [7:0] OP_LDI    = 8'h20;
    localparam logic [7:0] OP_NW_LO  = 8'h21;
    localparam logic [7:0] OP_NW_HI  = 8'h3E;
    localparam logic [7:0] OP_RET    = 8'h3F;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_RET_WAIT,
        ST_HALTED
    } dec_state_e;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_LDI,
        CL_NOWR,
        CL_RET,
        CL_HALT,
        CL_ILL
    } op_class_e;

    function automatic op_class_e op_class(input logic [7:0] op);
        op_class_e c;
        unique case (1'b1)
            op == OP_NOP:                      c = CL_NOP;
            op >= OP_ALU_LO && op <= OP_ALU_HI: c = CL_ALU;
            op == OP_LDI:                      c = CL_LDI;
            op >= OP_NW_LO && op <= OP_NW_HI:  c = CL_NOWR;
            op == OP_RET:                      c = CL_RET;
            op == OP_HALT:                     c = CL_HALT;
            default:                           c = CL_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// One pending bit per GPR; set wins over a same-cycle clear.
// Register 0 is hard-wired clear.
module decode_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int RA_W     = $clog2(NUM_REGS)
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic            set_en,
    input  logic [RA_W-1:0] set_addr,
    input  logic            clr_a_en,
    input  logic [RA_W-1:0] clr_a_addr,
    input  logic            clr_b_en,
    input  logic [RA_W-1:0] clr_b_addr,
    input  logic [RA_W-1:0] q_a_addr,
    input  logic [RA_W-1:0] q_b_addr,
    input  logic [RA_W-1:0] q_c_addr,
    output logic            q_a,
    output logic            q_b,
    output logic            q_c
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_nxt;

    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_a_en && clr_a_addr == RA_W'(i))
                pend_nxt[i] = 1'b0;
            if (clr_b_en && clr_b_addr == RA_W'(i))
                pend_nxt[i] = 1'b0;
            if (set_en && set_addr == RA_W'(i))
                pend_nxt[i] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

    assign q_a = pend[q_a_addr];
    assign q_b = pend[q_b_addr];
    assign q_c = pend[q_c_addr];

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: field split, hazard stall on scoreboard, ID/EX register,
// and a small RUN / RET_WAIT / HALTED control FSM.
module decode_pipe
    import decode_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 16,
    parameter  int RET_LAT  = 2,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    output logic [RA_W-1:0]   rf_addr_top,
    output logic [RA_W-1:0]   rf_addr_bot,
    input  logic [DATA_W-1:0] rf_data_top,
    input  logic [DATA_W-1:0] rf_data_bot,
    input  logic              wb_wen,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [7:0]        ex_opcode,
    output logic [RA_W-1:0]   ex_dst,
    output logic              ex_wen,
    output logic [DATA_W-1:0] ex_data_top,
    output logic [DATA_W-1:0] ex_data_bot,
    output logic              ret_pending,
    output logic              halted,
    output logic              illegal_opcode
);

    localparam int CNT_W = $clog2(RET_LAT + 1);

    logic [7:0]      opcode;
    logic [RA_W-1:0] dst;
    logic [RA_W-1:0] src_top;
    logic [RA_W-1:0] src_bot;
    logic [7:0]      imm;
    logic            unused_instr;

    assign opcode       = if_instr[7:0];
    assign dst          = if_instr[8+:RA_W];
    assign src_top      = if_instr[16+:RA_W];
    assign src_bot      = if_instr[24+:RA_W];
    assign imm          = if_instr[31:24];
    assign unused_instr = ^if_instr;

    assign rf_addr_top = src_top;
    assign rf_addr_bot = src_bot;

    op_class_e cls;
    logic      is_alu;
    logic      is_ldi;
    logic      is_ret;
    logic      is_halt;
    logic      is_ill;
    logic      wr_req;

    assign cls     = op_class(opcode);
    assign is_alu  = cls == CL_ALU;
    assign is_ldi  = cls == CL_LDI;
    assign is_ret  = cls == CL_RET;
    assign is_halt = cls == CL_HALT;
    assign is_ill  = cls == CL_ILL;
    assign wr_req  = (is_alu || is_ldi) && dst != '0;

    logic pend_top;
    logic pend_bot;
    logic pend_dst;
    logic hazard;

    // No forwarding: a same-cycle writeback does not release the stall.
    assign hazard = (is_alu && (pend_top || pend_bot))
                  || ((is_alu || is_ldi) && pend_dst);

    dec_state_e       state;
    dec_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             started;
    logic             in_run;
    logic             accept;
    logic             load;

    assign accept = if_valid && if_ready;
    assign load   = accept && !is_ill;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= ST_RUN;
            cnt         <= '0;
            ret_pending <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ret_pending <= state_nxt == ST_RET_WAIT;
            halted      <= state_nxt == ST_HALTED;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_RUN: begin
                if (accept && is_ret) begin
                    state_nxt = ST_RET_WAIT;
                    cnt_nxt   = CNT_W'(RET_LAT);
                end else if (accept && (is_halt || is_ill)) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_RET_WAIT: begin
                if (flush || cnt == '0) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        in_run   = state == ST_RUN;
        if_ready = in_run && started && !hazard
                 && (!ex_valid || ex_ready) && !flush;
    end

    // Holds off the first accept until one edge after reset release.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset)
            started <= 1'b0;
        else
            started <= 1'b1;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset)
            illegal_opcode <= 1'b0;
        else if (accept && is_ill)
            illegal_opcode <= 1'b1;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_dst      <= '0;
            ex_wen      <= 1'b0;
            ex_data_top <= '0;
            ex_data_bot <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (load) begin
            ex_valid  <= 1'b1;
            ex_opcode <= opcode;
            ex_dst    <= dst;
            ex_wen    <= wr_req;
            if (is_ldi) begin
                ex_data_top <= DATA_W'(imm);
                ex_data_bot <= '0;
            end else if (is_alu) begin
                ex_data_top <= rf_data_top;
                ex_data_bot <= rf_data_bot;
            end else begin
                ex_data_top <= '0;
                ex_data_bot <= '0;
            end
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    decode_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .RA_W     (RA_W)
    ) u_sb (
        .clock      (clock),
        .nreset     (nreset),
        .set_en     (load && wr_req),
        .set_addr   (dst),
        .clr_a_en   (wb_wen),
        .clr_a_addr (wb_addr),
        .clr_b_en   (flush && ex_valid && ex_wen),
        .clr_b_addr (ex_dst),
        .q_a_addr   (src_top),
        .q_b_addr   (src_bot),
        .q_c_addr   (dst),
        .q_a        (pend_top),
        .q_b        (pend_bot),
        .q_c        (pend_dst)
    );

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 8, register/data width.
REQ-002 Parameter NUM_REGS, default 16, GPR count; RA_W = clog2(NUM_REGS).
REQ-003 Parameter RET_LAT, default 2, cycles for the call-stack pop to reach the PC (>=1).
REQ-004 clock  in  1  single clock for all state.
REQ-005 nreset  in  1  asynchronous, active-low reset.
REQ-006 if_valid / if_ready  in/out  1/1  fetch handshake; if_instr  in  32  instruction word.
REQ-007 rf_addr_top / rf_addr_bot  out  RA_W each  combinational read addresses; rf_data_top / rf_data_bot  in  DATA_W each.
REQ-008 wb_wen  in  1, wb_addr  in  RA_W  writeback retiring a register write.
REQ-009 flush  in  1  kill decode and the ID/EX register.
REQ-010 ex_valid / ex_ready  out/in  1/1  ID/EX handshake; ex_opcode 8, ex_dst RA_W, ex_wen 1, ex_data_top / ex_data_bot DATA_W each, all out and registered.
REQ-011 ret_pending, halted, illegal_opcode  out  1 each, registered.

Function
REQ-012 Fields: opcode = instr[7:0]; dst = instr[8+:RA_W]; src_top = instr[16+:RA_W]; src_bot = instr[24+:RA_W]; imm = instr[31:24].
REQ-013 Classes: 0x00 NOP; 0x01-0x1F ALU (reads top+bot, writes dst); 0x20 LDI (writes dst; ex_data_top = imm[DATA_W-1:0], zero-extended when DATA_W > 8; ex_data_bot = 0); 0x21-0x3E no register write; 0x3F RET; 0xFF HALT; all other opcodes illegal.
REQ-014 Scoreboard: one pending bit per register; set on accept of a writing instruction; cleared by wb_wen at wb_addr; a clear and a set of the same register in one cycle leaves the bit set.
REQ-015 Hazard: an ALU instruction with a pending source bit, or any writer with a pending dst bit (WAW), holds if_ready low; no forwarding.
REQ-016 Accept when if_valid && if_ready; if_ready = state RUN && no hazard && (!ex_valid || ex_ready) && !flush.
REQ-017 The ID/EX register loads on accept; ex_valid clears when ex_ready is high and nothing is accepted; otherwise it holds (ex outputs stable while ex_valid && !ex_ready).
REQ-018 FSM RUN: RET accepted -> RET_WAIT with counter = RET_LAT; HALT accepted -> HALTED; illegal opcode accepted -> HALTED, illegal_opcode set, and that instruction is not forwarded to ID/EX.
REQ-019 RET_WAIT: ret_pending = 1; the counter decrements each cycle; returns to RUN on the cycle after it reaches 0; if_ready = 0 throughout.
REQ-020 HALTED: if_ready = 0 until reset; halted = 1; flush does not exit.
REQ-021 flush: clears ex_valid next cycle, clears the scoreboard bit of the ex_dst it discards if ex_wen, returns RET_WAIT to RUN, accepts nothing that cycle.
REQ-022 Latency: accept at cycle N -> ex_valid at N+1.
REQ-023 Register 0 is never marked pending; a write to it is dropped (ex_wen = 0).

Reset
REQ-024 On nreset low (asynchronous): state RUN, ex_valid 0, ex_* 0, scoreboard all 0, counter 0, ret_pending 0, halted 0, illegal_opcode 0.
REQ-025 Reset mid-RET_WAIT or while HALTED returns to RUN with no residual state; the first accept is permitted on the second clock edge after deassertion.

Structure
REQ-026 Opcode constants, class ranges, and FSM state encodings belong in a shared decode package.
REQ-027 The scoreboard is one sub-module, decode_scoreboard (NUM_REGS bits, set/clear/query ports).

Verification
REQ-028 ALU 0x05, dst 3, src 1/2, no hazard -> ex_valid next cycle, ex_data from rf, sb[3] = 1.
REQ-029 Back-to-back ALU dst 3, then ALU src_top 3 -> stalls until wb_wen/wb_addr = 3, then accepts the following cycle.
REQ-030 RET with RET_LAT = 2 -> ret_pending high, if_ready low; RUN resumes after the counter reaches 0 (3 cycles after accept); halted stays 0.
REQ-031 Opcode 0x80 -> illegal_opcode = 1, halted = 1, ex_valid stays 0, no accept until reset.
REQ-032 LDI dst 4, imm 0xA5 with ex_ready = 0 for 3 cycles -> outputs held stable; flush then clears ex_valid and sb[4].
REQ-033 nreset pulse during RET_WAIT -> all outputs at reset values; accept on the second clock edge after deassertion.
